// File: rtl/trackball_pkg.sv
// trackball_pkg: shared constants, types and helpers for the PS/2-to-trackball bridge.
package trackball_pkg;

  // Default accumulator width per axis (signed two's complement).
  localparam int ACC_W_DEF = 12;

  typedef logic signed [ACC_W_DEF-1:0] acc_t;

  // Field positions inside the hps_io ps2_mouse bus.
  localparam int PS2_TOG   = 24;
  localparam int PS2_DY_HI = 23;
  localparam int PS2_DY_LO = 16;
  localparam int PS2_DX_HI = 15;
  localparam int PS2_DX_LO = 8;
  localparam int PS2_YOVF  = 7;
  localparam int PS2_XOVF  = 6;
  localparam int PS2_YSGN  = 5;
  localparam int PS2_XSGN  = 4;

  // PS/2 movement is a 9-bit two's complement value {sign, mag}; an overflowed
  // axis contributes nothing, and flip mirrors the sign for cocktail cabinets.
  function automatic logic signed [8:0] ps2_delta9(input logic [7:0] mag,
                                                   input logic       sgn,
                                                   input logic       ovf,
                                                   input logic       flip);
    logic signed [8:0] d_s;
    if (ovf) begin
      d_s = 9'sd0;
    end else begin
      d_s = $signed({sgn ^ flip, mag});
    end
    return d_s;
  endfunction

  // acc + delta + step, clamped to the signed range of 'width' bits.
  // Done in 32 bits, which covers the ACC_W+2 headroom for any ACC_W <= 30.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                 input logic signed [31:0] delta,
                                                 input logic signed [31:0] step,
                                                 input int unsigned        width);
    logic signed [31:0] sum_s;
    logic signed [31:0] max_s;
    logic signed [31:0] min_s;
    sum_s = acc + delta + step;
    max_s = (32'sd1 <<< (width - 32'd1)) - 32'sd1;
    min_s = -max_s - 32'sd1;
    if (sum_s > max_s) begin
      sum_s = max_s;
    end else if (sum_s < min_s) begin
      sum_s = min_s;
    end else begin
      sum_s = sum_s;
    end
    return sum_s;
  endfunction

endpackage

// File: rtl/trackball_axis.sv
// trackball_axis: one axis of the bridge. Holds a saturating signed movement
// accumulator that is drained one count per step tick; every drained count
// sets the direction level and toggles the clock bit.
module trackball_axis
  import trackball_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic signed [ACC_W:0] delta,
  input  logic               pkt_event,
  input  logic               tick,
  input  logic               enable,
  output logic               dir,
  output logic               clk_bit,
  output logic               nonzero
);

  logic signed [ACC_W-1:0] acc_r;
  logic                    dir_r;
  logic                    clk_r;
  logic                    nonzero_r;

  logic signed [ACC_W-1:0] acc_next_s;
  logic                    dir_next_s;
  logic                    clk_next_s;
  logic signed [31:0]      delta_ext_s;
  logic signed [31:0]      step_s;

  // Next accumulator value: packet delta and drain step both land in the same cycle.
  always_comb begin
    acc_next_s  = acc_r;
    dir_next_s  = dir_r;
    clk_next_s  = clk_r;
    delta_ext_s = 32'sd0;
    step_s      = 32'sd0;
    if (!enable) begin
      acc_next_s = {ACC_W{1'b0}};
    end else begin
      if (tick && (acc_r != {ACC_W{1'b0}})) begin
        // Drain toward zero; dir reports which way the count was pending.
        step_s     = acc_r[ACC_W-1] ? 32'sd1 : -32'sd1;
        dir_next_s = ~acc_r[ACC_W-1];
        clk_next_s = ~clk_r;
      end else begin
        step_s = 32'sd0;
      end
      if (pkt_event) begin
        delta_ext_s = 32'(delta);
      end else begin
        delta_ext_s = 32'sd0;
      end
      acc_next_s = ACC_W'(sat_add(32'(acc_r), delta_ext_s, step_s, ACC_W));
    end
  end

  // Accumulator, direction/clock outputs and pending flag registers.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      acc_r     <= {ACC_W{1'b0}};
      dir_r     <= 1'b0;
      clk_r     <= 1'b0;
      nonzero_r <= 1'b0;
    end else begin
      acc_r     <= acc_next_s;
      dir_r     <= dir_next_s;
      clk_r     <= clk_next_s;
      nonzero_r <= (acc_next_s != {ACC_W{1'b0}});
    end
  end

  assign dir     = dir_r;
  assign clk_bit = clk_r;
  assign nonzero = nonzero_r;

endmodule

// File: rtl/trackball_quad.sv
// trackball_quad: converts hps_io PS/2 mouse packets into the 4-bit
// {x_dir, x_clk, y_dir, y_clk} trackball stream sampled by the game core.
module trackball_quad
  import trackball_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter int STEP_DIV = 24
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [24:0] ps2_mouse,
  input  logic        flip,
  input  logic        enable,
  output logic [3:0]  trak_o,
  output logic        busy_o
);

  localparam int DW    = ACC_W + 1;
  localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0]    div_r;
  logic                old_tog_r;
  logic                armed_r;
  logic                tick_s;
  logic                event_s;
  logic signed [DW-1:0] dx_s;
  logic signed [DW-1:0] dy_s;
  logic                x_dir_s;
  logic                x_clk_s;
  logic                x_nz_s;
  logic                y_dir_s;
  logic                y_clk_s;
  logic                y_nz_s;
  logic                unused_bits_s;

  // Buttons and spare bits of the mouse bus are not part of the trackball stream.
  assign unused_bits_s = ^ps2_mouse[3:0];

  // Tick and packet-event decode. armed_r masks the first cycle after reset,
  // where old_tog_r has not yet caught up with the bus.
  always_comb begin
    tick_s  = (div_r == DIV_LAST);
    event_s = armed_r && enable && (ps2_mouse[PS2_TOG] != old_tog_r);
  end

  // Per-axis delta: 9-bit PS/2 value sign-extended to accumulator width + 1.
  always_comb begin
    dx_s = DW'(ps2_delta9(ps2_mouse[PS2_DX_HI:PS2_DX_LO], ps2_mouse[PS2_XSGN],
                          ps2_mouse[PS2_XOVF], flip));
    dy_s = DW'(ps2_delta9(ps2_mouse[PS2_DY_HI:PS2_DY_LO], ps2_mouse[PS2_YSGN],
                          ps2_mouse[PS2_YOVF], flip));
  end

  // Toggle tracking keeps following the bus even while disabled, so
  // re-enabling never replays a packet that arrived in the meantime.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      old_tog_r <= 1'b0;
      armed_r   <= 1'b0;
    end else begin
      old_tog_r <= ps2_mouse[PS2_TOG];
      armed_r   <= 1'b1;
    end
  end

  // Free-running step divider shared by both axes; parked at 0 while disabled.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      div_r <= {DIV_W{1'b0}};
    end else if (!enable || tick_s) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  trackball_axis #(
    .ACC_W (ACC_W)
  ) u_axis_x (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .delta     (dx_s),
    .pkt_event (event_s),
    .tick      (tick_s),
    .enable    (enable),
    .dir       (x_dir_s),
    .clk_bit   (x_clk_s),
    .nonzero   (x_nz_s)
  );

  trackball_axis #(
    .ACC_W (ACC_W)
  ) u_axis_y (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .delta     (dy_s),
    .pkt_event (event_s),
    .tick      (tick_s),
    .enable    (enable),
    .dir       (y_dir_s),
    .clk_bit   (y_clk_s),
    .nonzero   (y_nz_s)
  );

  // All four stream bits and both pending flags come straight from axis registers.
  assign trak_o = {x_dir_s, x_clk_s, y_dir_s, y_clk_s};
  assign busy_o = x_nz_s | y_nz_s;

endmodule

// File: tb/tb_trackball_quad.sv
// tb_trackball_quad: scoreboard bench. A behavioural model predicts each
// trak_o change (value and cycle) into a queue; a negedge monitor pops and
// compares whenever trak_o moves. busy_o is compared every cycle.
module tb_trackball_quad;

  localparam int STEP_DIV = 24;
  localparam int AMAX     = 2047;
  localparam int AMIN     = -2048;

  typedef struct {
    logic [3:0] v;
    int         at;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [24:0] ps2_mouse;
  logic        flip;
  logic        enable;
  logic [3:0]  trak_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state.
  int         m_ax = 0;
  int         m_ay = 0;
  int         m_div = 0;
  bit         m_old = 1'b0;
  bit         m_armed = 1'b0;
  logic [3:0] m_trak = 4'b0000;
  int         m_xedges = 0;
  int         m_yedges = 0;

  // Monitor state.
  logic [3:0] prev_trak = 4'b0000;
  int         d_xedges = 0;
  int         d_yedges = 0;

  always #5 clk_sys = ~clk_sys;

  trackball_quad #(
    .ACC_W    (12),
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_mouse (ps2_mouse),
    .flip      (flip),
    .enable    (enable),
    .trak_o    (trak_o),
    .busy_o    (busy_o)
  );

  function automatic int clamp(input int v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  function automatic int mk_delta(input bit [7:0] mag, input bit sgn, input bit ovf, input bit fl);
    if (ovf) return 0;
    return (sgn ^ fl) ? int'(mag) - 256 : int'(mag);
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Predict the effect of the coming clock edge from the inputs now applied.
  task automatic model_edge();
    bit         ev;
    bit         tk;
    int         dx;
    int         dy;
    int         sx;
    int         sy;
    logic [3:0] nt;
    exp_t       e;
    if (!reset_n) begin
      m_ax = 0; m_ay = 0; m_div = 0; m_old = 1'b0; m_armed = 1'b0;
      nt = 4'b0000;
    end else begin
      ev = m_armed && enable && (ps2_mouse[24] != m_old);
      m_old = ps2_mouse[24];
      m_armed = 1'b1;
      tk = enable && (m_div == STEP_DIV - 1);
      m_div = (!enable || tk) ? 0 : m_div + 1;
      dx = ev ? mk_delta(ps2_mouse[15:8], ps2_mouse[4], ps2_mouse[6], flip) : 0;
      dy = ev ? mk_delta(ps2_mouse[23:16], ps2_mouse[5], ps2_mouse[7], flip) : 0;
      nt = m_trak;
      sx = 0;
      sy = 0;
      if (!enable) begin
        m_ax = 0;
        m_ay = 0;
      end else begin
        if (tk && m_ax != 0) begin
          sx = (m_ax < 0) ? 1 : -1;
          nt[3] = (m_ax > 0);
          nt[2] = ~nt[2];
          m_xedges++;
        end
        if (tk && m_ay != 0) begin
          sy = (m_ay < 0) ? 1 : -1;
          nt[1] = (m_ay > 0);
          nt[0] = ~nt[0];
          m_yedges++;
        end
        m_ax = clamp(m_ax + dx + sx);
        m_ay = clamp(m_ay + dy + sy);
      end
    end
    if (nt != m_trak) begin
      e.v  = nt;
      e.at = cyc_n + 1;
      exp_q.push_back(e);
    end
    m_trak = nt;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk_sys);
    cyc_n++;
    #1;
    check_int("busy", int'(busy_o), (m_ax != 0 || m_ay != 0) ? 1 : 0);
  endtask

  task automatic pkt(input logic [7:0] dx, input logic [7:0] dy,
                     input bit sx, input bit sy, input bit ox, input bit oy);
    ps2_mouse[24]    = ~ps2_mouse[24];
    ps2_mouse[23:16] = dy;
    ps2_mouse[15:8]  = dx;
    ps2_mouse[7]     = oy;
    ps2_mouse[6]     = ox;
    ps2_mouse[5]     = sy;
    ps2_mouse[4]     = sx;
    cyc();
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((m_ax != 0 || m_ay != 0) && n < max_cyc) begin
      cyc();
      n++;
    end
    repeat (2) cyc();
    check_int("drain_done", (m_ax != 0 || m_ay != 0) ? 1 : 0, 0);
    check_int("queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: every change on trak_o must match the next predicted change, on time.
  always @(negedge clk_sys) begin
    if (trak_o !== prev_trak) begin
      if (trak_o[2] !== prev_trak[2]) d_xedges++;
      if (trak_o[0] !== prev_trak[0]) d_yedges++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL trak_unexpected: got %b at cycle %0d, no change expected", trak_o, cyc_n);
      end else begin
        mon_e = exp_q.pop_front();
        if (trak_o !== mon_e.v || cyc_n != mon_e.at) begin
          errors++;
          $display("FAIL trak_change: got %b at cycle %0d expected %b at cycle %0d",
                   trak_o, cyc_n, mon_e.v, mon_e.at);
        end
      end
      prev_trak = trak_o;
    end
  end

  initial begin
    int bx;
    int by;
    int mx;
    reset_n   = 1'b0;
    ps2_mouse = 25'd0;
    flip      = 1'b0;
    enable    = 1'b1;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    check_int("reset_trak", int'(trak_o), 0);
    check_int("reset_busy", int'(busy_o), 0);

    // dX = +5: five x edges with x_dir = 1, y static.
    bx = d_xedges; by = d_yedges;
    pkt(8'd5, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_int("busy_after_pkt", int'(busy_o), 1);
    drain(200);
    check_int("x5_edges", d_xedges - bx, 5);
    check_int("x5_yedges", d_yedges - by, 0);
    check_int("x5_dir", int'(trak_o[3]), 1);

    // dY = 3, Y sign 1 with flip: +3, y_dir = 1 (X sign set so X delta is +0).
    flip = 1'b1;
    bx = d_xedges; by = d_yedges;
    pkt(8'd0, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    drain(200);
    check_int("yflip_edges", d_yedges - by, 3);
    check_int("yflip_xedges", d_xedges - bx, 0);
    check_int("yflip_dir", int'(trak_o[1]), 1);

    // Same packet without flip: 9-bit value 0x103 = -253, y_dir = 0.
    flip = 1'b0;
    by = d_yedges;
    pkt(8'd0, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(260 * STEP_DIV);
    check_int("yneg_edges", d_yedges - by, 253);
    check_int("yneg_dir", int'(trak_o[1]), 0);

    // 30 back-to-back +127 packets saturate at 2047.
    bx = d_xedges; mx = m_xedges;
    for (int i = 0; i < 30; i++) pkt(8'd127, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(2100 * STEP_DIV);
    check_int("sat_edges", d_xedges - bx, m_xedges - mx);
    check_int("sat_min_edges", (d_xedges - bx >= AMAX) ? 1 : 0, 1);

    // X overflow masks X only.
    bx = d_xedges; by = d_yedges;
    pkt(8'd50, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    drain(200);
    check_int("ovf_xedges", d_xedges - bx, 0);
    check_int("ovf_yedges", d_yedges - by, 2);

    // Packet on the same cycle as a tick draining acc = 1: both take effect.
    bx = d_xedges;
    pkt(8'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 2 * STEP_DIV && m_div != STEP_DIV - 1; n++) cyc();
    pkt(8'd4, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(200);
    check_int("tick_pkt_edges", d_xedges - bx, 5);

    // Enable low mid-drain clears; a toggle while disabled is not replayed.
    pkt(8'd10, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3 * STEP_DIV) cyc();
    enable = 1'b0;
    bx = d_xedges;
    repeat (5) cyc();
    ps2_mouse[24]   = ~ps2_mouse[24];
    ps2_mouse[15:8] = 8'd9;
    repeat (5) cyc();
    enable = 1'b1;
    repeat (4 * STEP_DIV) cyc();
    check_int("enable_edges", d_xedges - bx, 0);
    check_int("enable_busy", int'(busy_o), 0);

    // Negative saturation, -1 at the floor, then reset mid-drain.
    for (int i = 0; i < 9; i++) pkt(8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pkt(8'd255, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pkt(8'd255, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (100) cyc();
    reset_n = 1'b0;
    cyc();
    check_int("rst_trak", int'(trak_o), 0);
    check_int("rst_busy", int'(busy_o), 0);
    ps2_mouse[24]   = 1'b1;
    ps2_mouse[15:8] = 8'd7;
    repeat (5) cyc();
    reset_n = 1'b1;
    repeat (2 * STEP_DIV) cyc();
    check_int("rst_trak_after", int'(trak_o), 0);

    // Randomized traffic: packets, flip, overflow and enable drops.
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom_range(29) != 0);
      if ($urandom_range(15) == 0) flip = ~flip;
      if ($urandom_range(3) == 0) begin
        pkt(8'($urandom_range(255)), 8'($urandom_range(255)),
            1'($urandom_range(1)), 1'($urandom_range(1)),
            ($urandom_range(7) == 0), ($urandom_range(7) == 0));
      end else begin
        cyc();
      end
    end
    enable = 1'b0;
    repeat (3) cyc();
    enable = 1'b1;
    repeat (3) cyc();
    check_int("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
